// File: rtl/nn_pkg.sv
// Shared constants and types for the fully-connected classifier stage.
package nn_pkg;

   localparam int NoOfKernels = 2;
   localparam int NoOfShapes  = 4;
   localparam int ACC_W       = 17 + $clog2(NoOfKernels * 4);
   localparam int DOT_W       = 19;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } fc_state_t;

   typedef logic [3:0][7:0] pooled_t;

endpackage

// File: rtl/fc_dot4.sv
// Combinational 4-way dot product: unsigned 8-bit pixels times packed signed 8-bit weights.
module fc_dot4
   import nn_pkg::*;
(
   input  logic [3:0][7:0]           pixels,
   input  logic [31:0]               weights,
   output logic signed [DOT_W-1:0]   sum
);

   logic signed [16:0] prod [4];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_prod
         logic signed [16:0] px_ext;
         logic signed [16:0] w_ext;
         // Pixel is unsigned, so it is zero-extended before the signed multiply.
         assign px_ext   = {9'b0, pixels[gi]};
         assign w_ext    = {{9{weights[8*gi+7]}}, weights[8*gi +: 8]};
         assign prod[gi] = px_ext * w_ext;
      end
   endgenerate

   always_comb begin
      sum = '0;
      for (int j = 0; j < 4; j++) begin
         sum = sum + {{(DOT_W-17){prod[j][16]}}, prod[j]};
      end
   end

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected output stage: streams weights from RAM, scores every shape and reports the best.
module fc_classifier #(
   parameter int NK    = nn_pkg::NoOfKernels,
   parameter int NS    = nn_pkg::NoOfShapes,
   parameter int AW    = 5,
   parameter int ACC_W = nn_pkg::ACC_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NK-1:0][3:0][7:0] pooled_pixels,
   output logic                  w_rd_en,
   output logic [AW-1:0]         w_addr,
   input  logic [31:0]           w_data,
   output logic                  busy,
   output logic [7:0]            result,
   output logic [ACC_W-1:0]      score,
   output logic                  result_valid
);

   import nn_pkg::*;

   localparam int KW        = (NK > 1) ? $clog2(NK) : 1;
   localparam int SW        = (NS > 1) ? $clog2(NS) : 1;
   localparam int LAST_ADDR = NS * NK - 1;

   fc_state_t state_reg, state_next;

   logic [AW-1:0] addr_reg;
   logic [KW-1:0] kern_reg;
   logic [SW-1:0] shape_reg;

   logic          tag_valid_reg;
   logic          tag_last_reg;
   logic [KW-1:0] tag_kern_reg;
   logic [SW-1:0] tag_shape_reg;

   pooled_t pix_reg [NK];
   pooled_t cur_pix;

   logic signed [DOT_W-1:0] dot;
   logic signed [ACC_W-1:0] cand;
   logic signed [ACC_W-1:0] acc_reg, acc_next;
   logic signed [ACC_W-1:0] best_reg, best_next;
   logic [SW-1:0]           best_idx_reg, best_idx_next;

   logic [7:0]       result_reg;
   logic [ACC_W-1:0] score_reg;

   logic start_run;
   logic last_issue;

   assign start_run  = (state_reg == IDLE) && start;
   assign last_issue = (addr_reg == AW'(LAST_ADDR));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      w_rd_en      = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            w_rd_en = 1'b1;
            busy    = 1'b1;
            if (last_issue) state_next = DRAIN;
         end
         DRAIN: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            busy         = 1'b1;
            result_valid = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Issue side: word address plus the shape/kernel it decodes to.
   always_ff @(posedge clk) begin
      if (rst || start_run) begin
         addr_reg  <= '0;
         kern_reg  <= '0;
         shape_reg <= '0;
      end else if ((state_reg == RUN) && !last_issue) begin
         addr_reg <= addr_reg + AW'(1);
         if (kern_reg == KW'(NK - 1)) begin
            kern_reg  <= '0;
            shape_reg <= shape_reg + SW'(1);
         end else begin
            kern_reg <= kern_reg + KW'(1);
         end
      end
   end

   // The tag lines up with w_data, which returns one cycle after the read.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid_reg <= 1'b0;
         tag_last_reg  <= 1'b0;
         tag_kern_reg  <= '0;
         tag_shape_reg <= '0;
      end else begin
         tag_valid_reg <= w_rd_en;
         tag_last_reg  <= (kern_reg == KW'(NK - 1));
         tag_kern_reg  <= kern_reg;
         tag_shape_reg <= shape_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NK; k++) pix_reg[k] <= '0;
      end else if (start_run) begin
         for (int k = 0; k < NK; k++) pix_reg[k] <= pooled_pixels[k];
      end
   end

   assign cur_pix = pix_reg[tag_kern_reg];

   fc_dot4 u_dot4 (
      .pixels  (cur_pix),
      .weights (w_data),
      .sum     (dot)
   );

   assign cand = acc_reg + {{(ACC_W-DOT_W){dot[DOT_W-1]}}, dot};

   // Strict compare keeps the lower shape index on ties; shape 0 always seeds best.
   always_comb begin
      acc_next      = acc_reg;
      best_next     = best_reg;
      best_idx_next = best_idx_reg;
      if (tag_valid_reg) begin
         if (tag_last_reg) begin
            acc_next = '0;
            if ((tag_shape_reg == '0) || (cand > best_reg)) begin
               best_next     = cand;
               best_idx_next = tag_shape_reg;
            end
         end else begin
            acc_next = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start_run) begin
         acc_reg      <= '0;
         best_reg     <= '0;
         best_idx_reg <= '0;
      end else begin
         acc_reg      <= acc_next;
         best_reg     <= best_next;
         best_idx_reg <= best_idx_next;
      end
   end

   // The final word is consumed during DRAIN, so the winner is captured on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg <= '0;
         score_reg  <= '0;
      end else if (state_reg == DRAIN) begin
         result_reg <= 8'(best_idx_next);
         score_reg  <= best_next;
      end
   end

   assign w_addr = addr_reg;
   assign result = result_reg;
   assign score  = score_reg;

endmodule
